// File: rtl/sub_2p.sv
// Four-stage pipelined subtractor: diff = (x - y) mod 2^WIDTH, carry broken at segment edges.
// Optional borrow output enabled by defining SUB_2P_BORROW_OUT_EN.
module sub_2p #(
    parameter int WIDTH  = 22,
    parameter int WIDTH1 = 7,
    parameter int WIDTH2 = 7,
    parameter int WIDTH3 = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             valid_in,
    output logic [WIDTH-1:0] diff,
    output logic             valid_out
`ifdef SUB_2P_BORROW_OUT_EN
    ,
    output logic             borrow
`endif
);

    // Handshake: valid_in qualifies x/y in the cycle it is high; valid_out qualifies
    // diff exactly four edges later. There is no ready/backpressure, one sample per cycle.

    localparam int L_HI = WIDTH1 - 1;
    localparam int M_LO = WIDTH1;
    localparam int M_HI = WIDTH1 + WIDTH2 - 1;
    localparam int H_LO = WIDTH1 + WIDTH2;

    // stage 0: captured operands, y already bit-inverted
    logic [WIDTH1-1:0] xl0, yl0;
    logic [WIDTH2-1:0] xm0, ym0;
    logic [WIDTH3-1:0] xh0, yh0;
    logic              v0;

    // stage 1: independent segment sums
    logic [WIDTH1-1:0] l1;
    logic [WIDTH2-1:0] m1;
    logic [WIDTH3-1:0] h1;
    logic              cl1, cm1, v1;

    // stage 2: LSB carry folded into middle, middle carry into MSB
    logic [WIDTH1-1:0] l2;
    logic [WIDTH2-1:0] m2;
    logic [WIDTH3-1:0] h2;
    logic              cm2, v2;

    // stage 3: output registers
    logic [WIDTH1-1:0] l3;
    logic [WIDTH2-1:0] m3;
    logic [WIDTH3-1:0] h3;
    logic              v3;

    logic [WIDTH1:0] sum_l1;
    logic [WIDTH2:0] sum_m1;
    logic [WIDTH3:0] sum_h1;
    logic [WIDTH2:0] sum_m2;
    logic [WIDTH3:0] sum_h2;
    logic [WIDTH3:0] sum_h3;

    // The +1 on the LSB segment completes the two's complement of y.
    assign sum_l1 = {1'b0, xl0} + {1'b0, yl0} + {{WIDTH1{1'b0}}, 1'b1};
    assign sum_m1 = {1'b0, xm0} + {1'b0, ym0};
    assign sum_h1 = {1'b0, xh0} + {1'b0, yh0};
    assign sum_m2 = {1'b0, m1} + {{WIDTH2{1'b0}}, cl1};
    assign sum_h2 = {1'b0, h1} + {{WIDTH3{1'b0}}, cm1};
    assign sum_h3 = {1'b0, h2} + {{WIDTH3{1'b0}}, cm2};

    always_ff @(posedge clk) begin
        if (reset) begin
            xl0 <= '0;
            yl0 <= '0;
            xm0 <= '0;
            ym0 <= '0;
            xh0 <= '0;
            yh0 <= '0;
            v0  <= 1'b0;
            l1  <= '0;
            m1  <= '0;
            h1  <= '0;
            cl1 <= 1'b0;
            cm1 <= 1'b0;
            v1  <= 1'b0;
            l2  <= '0;
            m2  <= '0;
            h2  <= '0;
            cm2 <= 1'b0;
            v2  <= 1'b0;
            l3  <= '0;
            m3  <= '0;
            h3  <= '0;
            v3  <= 1'b0;
        end else begin
            xl0 <= x[L_HI:0];
            yl0 <= ~y[L_HI:0];
            xm0 <= x[M_HI:M_LO];
            ym0 <= ~y[M_HI:M_LO];
            xh0 <= x[WIDTH-1:H_LO];
            yh0 <= ~y[WIDTH-1:H_LO];
            v0  <= valid_in;

            l1  <= sum_l1[WIDTH1-1:0];
            cl1 <= sum_l1[WIDTH1];
            m1  <= sum_m1[WIDTH2-1:0];
            cm1 <= sum_m1[WIDTH2];
            h1  <= sum_h1[WIDTH3-1:0];
            v1  <= v0;

            l2  <= l1;
            m2  <= sum_m2[WIDTH2-1:0];
            cm2 <= sum_m2[WIDTH2];
            h2  <= sum_h2[WIDTH3-1:0];
            v2  <= v1;

            l3  <= l2;
            m3  <= m2;
            h3  <= sum_h3[WIDTH3-1:0];
            v3  <= v2;
        end
    end

    assign diff      = {h3, m3, l3};
    assign valid_out = v3;

`ifdef SUB_2P_BORROW_OUT_EN
    // At most one of the three MSB additions can carry out (the middle segment
    // delivers at most one carry in total), so OR-ing them gives the true carry-out.
    logic hc1, hc2, borrow_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hc1      <= 1'b0;
            hc2      <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            hc1      <= sum_h1[WIDTH3];
            hc2      <= hc1 | sum_h2[WIDTH3];
            borrow_q <= ~(hc2 | sum_h3[WIDTH3]);
        end
    end

    assign borrow = borrow_q;
`else
    // MSB carry-outs are discarded: the result wraps modulo 2^WIDTH.
    logic unused_carries;
    assign unused_carries = sum_h1[WIDTH3] ^ sum_h2[WIDTH3] ^ sum_h3[WIDTH3];
`endif

endmodule
